// File: rtl/seven_seg_pkg.sv
// Shared 7-segment encodings (active-low, bit0=a .. bit6=g) and the reverse decoder
// used by both the display driver and the display reader.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } rd_state_t;

    // Blank is a legal pattern that decodes to nibble 0 with the blank flag raised.
    function automatic seg_dec_t seg_to_nibble(input logic [6:0] seg);
        seg_dec_t d;
        d.legal  = 1'b1;
        d.blank  = 1'b0;
        d.nibble = 4'h0;
        case (seg)
            SEG_0:     d.nibble = 4'h0;
            SEG_1:     d.nibble = 4'h1;
            SEG_2:     d.nibble = 4'h2;
            SEG_3:     d.nibble = 4'h3;
            SEG_4:     d.nibble = 4'h4;
            SEG_5:     d.nibble = 4'h5;
            SEG_6:     d.nibble = 4'h6;
            SEG_7:     d.nibble = 4'h7;
            SEG_8:     d.nibble = 4'h8;
            SEG_9:     d.nibble = 4'h9;
            SEG_A:     d.nibble = 4'hA;
            SEG_B:     d.nibble = 4'hB;
            SEG_C:     d.nibble = 4'hC;
            SEG_D:     d.nibble = 4'hD;
            SEG_E:     d.nibble = 4'hE;
            SEG_F:     d.nibble = 4'hF;
            SEG_BLANK: d.blank  = 1'b1;
            default:   d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Synchronizes the display bus and emits a single sample strobe once {sel,seg}
// has stayed unchanged for STABLE_CYC cycles.
module seg_stable_filter #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [DIGITS-1:0] dig_sel_in,
    output logic              strobe_o,
    output logic [DIGITS-1:0] sel_o,
    output logic [6:0]        seg_o
);

    localparam int W     = DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    logic [W-1:0]     sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed;

    assign changed = (sync2_q != prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizers reset to the idle bus (everything off) so no strobe sees a false multi-select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {dig_sel_in, seg_in};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign strobe_o = !changed && (cnt_q == CNT_W'(STABLE_CYC - 1));
    assign sel_o    = sync2_q[W-1:7];
    assign seg_o    = sync2_q[6:0];

endmodule

// File: rtl/seven_seg_reader.sv
// Reads back a multiplexed active-low 7-segment bus: filters each digit, decodes it
// and assembles one frame value per complete in-order scan.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic [DIGITS-1:0]   dig_sel_in,
    output logic [4*DIGITS-1:0] value_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [DIGITS-1:0]   blank_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              strobe;
    logic [DIGITS-1:0] f_sel;
    logic [6:0]        f_seg;

    seg_stable_filter #(
        .DIGITS     (DIGITS),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel_in (dig_sel_in),
        .strobe_o   (strobe),
        .sel_o      (f_sel),
        .seg_o      (f_seg)
    );

    logic [DIGITS-1:0] sel_low;
    logic              none_sel, multi_sel, is_last;
    logic [IDX_W-1:0]  idx;
    seg_dec_t          dec;

    assign sel_low   = ~f_sel;
    assign none_sel  = (sel_low == '0);
    assign multi_sel = ((sel_low & (sel_low - 1'b1)) != '0);
    assign is_last   = (idx == IDX_W'(DIGITS - 1));
    assign dec       = seg_to_nibble(f_seg);

    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_low[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    rd_state_t           state_q, state_d;
    logic [IDX_W-1:0]    exp_q, exp_d;
    logic [4*DIGITS-1:0] frame_val_q, frame_val_d;
    logic [DIGITS-1:0]   frame_blank_q, frame_blank_d;
    logic                pend_err_q, pend_err_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic                store, restart;

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        frame_val_d   = frame_val_q;
        frame_blank_d = frame_blank_q;
        pend_err_d    = pend_err_q;
        done_d        = 1'b0;
        value_d       = value_q;
        blank_d       = blank_q;
        err_d         = err_q;
        valid_d       = 1'b0;
        store         = 1'b0;
        restart       = 1'b0;

        if (done_q) begin
            value_d    = frame_val_q;
            blank_d    = frame_blank_q;
            err_d      = pend_err_q;
            valid_d    = 1'b1;
            pend_err_d = 1'b0;
        end

        if (strobe && !none_sel) begin
            if (multi_sel) begin
                pend_err_d = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (idx == '0) store = 1'b1;
                    end
                    ST_COLLECT: begin
                        // A repeated scan of the previous digit is normal refresh, not an error.
                        if (idx == exp_q) begin
                            store = 1'b1;
                        end else if (idx == exp_q - 1'b1) begin
                            store = 1'b0;
                        end else if (idx == '0) begin
                            store   = 1'b1;
                            restart = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        if (store) begin
            if (restart) begin
                pend_err_d    = 1'b0;
                frame_blank_d = '0;
            end
            frame_val_d[4*idx +: 4] = dec.nibble;
            frame_blank_d[idx]      = dec.blank;
            if (!dec.legal) pend_err_d = 1'b1;
            if (is_last) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                exp_d   = idx + 1'b1;
                state_d = ST_COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            exp_q         <= '0;
            frame_val_q   <= '0;
            frame_blank_q <= '0;
            pend_err_q    <= 1'b0;
            done_q        <= 1'b0;
            value_q       <= '0;
            blank_q       <= '0;
            err_q         <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            frame_val_q   <= frame_val_d;
            frame_blank_q <= frame_blank_d;
            pend_err_q    <= pend_err_d;
            done_q        <= done_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            valid_q       <= valid_d;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign blank_o = blank_q;

endmodule
